// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
//
// Purpose:
//   Downstream stage of the FIR filter. Accepts the filtered AXI4-Stream
//   sample stream, keeps one sample out of every D (plus any sample carrying
//   an input tlast), and re-emits the kept samples on its own AXI4-Stream
//   master. An output tlast is inserted every FRAME_LEN output samples or
//   whenever an input tlast is kept. A 2-entry output buffer sustains one
//   transfer per cycle under backpressure.
//
// Ports:
//   s_axis_aclk     : single clock for both stream sides
//   s_axis_aresetn  : asynchronous, active-low reset
//   enable          : 1 = decimate, 0 = hold off input, clear phase/olen and
//                     capture decim_factor
//   decim_factor    : decimation factor D (0 and 1 both mean pass-through)
//   s_axis_*        : input stream (tdata, tstrb, tlast, tvalid, tready)
//   m_axis_*        : decimated output stream (tdata, tstrb, tlast, tvalid,
//                     tready)
//   frame_count     : number of completed output frames, wraps at 2^16
//
// Handshake: a beat transfers on a rising edge where tvalid && tready.
//   s_axis_tready depends only on enable and the buffer count (never on
//   s_axis_tvalid or m_axis_tready); m_axis_tvalid is high whenever the
//   buffer holds an entry, and the head stays stable until it is popped.
// -----------------------------------------------------------------------------
module fir_decimator #(
  parameter int TDATA_WIDTH = 32,
  parameter int DECIM_WIDTH = 8,
  parameter int FRAME_LEN   = 256
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  input  logic                     enable,
  input  logic [DECIM_WIDTH-1:0]   decim_factor,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [15:0]              frame_count
);

  localparam int STRB_W = TDATA_WIDTH / 8;
  localparam int OLEN_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [OLEN_W-1:0]      OLEN_LAST = OLEN_W'(FRAME_LEN - 1);
  localparam logic [DECIM_WIDTH-1:0] D_ONE     = DECIM_WIDTH'(1);

  // Control state
  logic [DECIM_WIDTH-1:0] d_reg;
  logic [DECIM_WIDTH-1:0] phase;
  logic [OLEN_W-1:0]      olen;

  // Output buffer: two entries addressed by 1-bit read/write pointers
  logic [TDATA_WIDTH-1:0] buf_data [2];
  logic [STRB_W-1:0]      buf_strb [2];
  logic                   buf_last [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;

  logic accept;
  logic keep;
  logic push;
  logic pop;
  logic out_last;

  assign s_axis_tready = enable && (count != 2'd2);
  assign m_axis_tvalid = (count != 2'd0);

  // Head of the buffer; entries reset to zero so the outputs read zero
  // after reset.
  assign m_axis_tdata  = buf_data[rd_ptr];
  assign m_axis_tstrb  = buf_strb[rd_ptr];
  assign m_axis_tlast  = buf_last[rd_ptr];

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign keep     = (phase == '0) || s_axis_tlast;
  assign push     = accept && keep;
  assign pop      = m_axis_tvalid && m_axis_tready;
  // An input tlast landing on the last frame slot still yields a single
  // output tlast and a single frame increment.
  assign out_last = (olen == OLEN_LAST) || s_axis_tlast;

  // Decimation phase, frame position and factor capture
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      d_reg       <= D_ONE;
      phase       <= '0;
      olen        <= '0;
      frame_count <= '0;
    end else if (!enable) begin
      // Idle: track the requested factor (0 treated as 1), clear position.
      d_reg <= (decim_factor == '0) ? D_ONE : decim_factor;
      phase <= '0;
      olen  <= '0;
    end else if (accept) begin
      if (s_axis_tlast || (phase == d_reg - D_ONE)) begin
        phase <= '0;
      end else begin
        phase <= phase + D_ONE;
      end
      if (keep) begin
        if (out_last) begin
          olen        <= '0;
          frame_count <= frame_count + 16'd1;
        end else begin
          olen <= olen + OLEN_W'(1);
        end
      end
    end
  end

  // Output buffer; push at count=2 cannot happen because tready is low then.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_strb[i] <= '0;
        buf_last[i] <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= s_axis_tdata;
        buf_strb[wr_ptr] <= s_axis_tstrb;
        buf_last[wr_ptr] <= out_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_decimator
//
// Self-checking bench for fir_decimator (FRAME_LEN = 4 so frame boundaries
// show up quickly). Inputs are driven 1 time unit after the rising edge;
// everything is observed on the falling edge. A reference model predicts
// which accepted samples survive decimation, their output tlast, the buffer
// occupancy and the frame count; kept samples go into an expected queue and
// are matched in order against every output transfer.
// -----------------------------------------------------------------------------
module tb_fir_decimator;

  localparam int TW   = 32;
  localparam int SW   = TW / 8;
  localparam int DW   = 8;
  localparam int FLEN = 4;
  localparam int EW   = TW + SW + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [DW-1:0] decim_factor = '0;
  logic [TW-1:0] s_tdata = '0;
  logic [SW-1:0] s_tstrb = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [TW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [15:0]   frame_count;

  fir_decimator #(
    .TDATA_WIDTH(TW),
    .DECIM_WIDTH(DW),
    .FRAME_LEN  (FLEN)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .enable        (enable),
    .decim_factor  (decim_factor),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .frame_count   (frame_count)
  );

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [EW-1:0] exp_q[$];
  int            m_d      = 1;   // active factor
  int            m_pos    = 0;   // samples since last phase restart
  int            m_olen   = 0;   // outputs within current frame
  int            m_occ    = 0;   // samples held in the output buffer
  int            m_frames = 0;   // completed frames mod 2^16

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          kept;
    logic          olast;
    if (!rst_n) begin
      exp_q.delete();
      m_d = 1; m_pos = 0; m_olen = 0; m_occ = 0; m_frames = 0;
    end else begin
      check("m_tvalid", {63'd0, m_tvalid}, {63'd0, (m_occ > 0)});
      check("s_tready", {63'd0, s_tready}, {63'd0, (enable && (m_occ < 2))});
      check("frame_count", {48'd0, frame_count}, 64'(m_frames));
      // Output transfer completing at the coming edge
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {32'd0, m_tdata}, {32'd0, e[TW-1:0]});
          check("out_strb", {60'd0, m_tstrb}, {60'd0, e[TW+SW-1:TW]});
          check("out_last", {63'd0, m_tlast}, {63'd0, e[EW-1]});
        end
        m_occ--;
      end
      // Input transfer completing at the coming edge
      if (s_tvalid && s_tready) begin
        kept = ((m_pos % m_d) == 0) || s_tlast;
        m_pos = s_tlast ? 0 : m_pos + 1;
        if (kept) begin
          olast = (m_olen == FLEN - 1) || s_tlast;
          exp_q.push_back({olast, s_tstrb, s_tdata});
          m_occ++;
          if (olast) begin
            m_olen = 0;
            m_frames = (m_frames + 1) % 65536;
          end else begin
            m_olen++;
          end
        end
      end
      if (!enable) begin
        m_d = (decim_factor == 0) ? 1 : int'(decim_factor);
        m_pos = 0;
        m_olen = 0;
      end
    end
  end

  // ---------------------------------------------------------------- output ready driver
  int ready_mode = 0; // 0: always ready, 1: ready about 1 cycle in 3, 2: stalled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 2) == 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_factor(input int d);
    enable = 1'b0;
    decim_factor = DW'(d);
    cycles(2);
    enable = 1'b1;
  endtask

  task automatic send(input logic [15:0] sample, input logic last);
    logic ok;
    int   n;
    s_tdata  = {16'($urandom), sample};
    s_tstrb  = SW'($urandom);
    s_tlast  = last;
    s_tvalid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 64'd1, 64'd0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_occ != 0 || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(m_occ + exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int d;
    int n;
    #2;
    // Reset values
    check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("rst_s_tready", {63'd0, s_tready}, 64'd0);
    check("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
    check("rst_m_tstrb", {60'd0, m_tstrb}, 64'd0);
    check("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    check("rst_frame_count", {48'd0, frame_count}, 64'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Pass-through: factor 0 behaves as 1
    ready_mode = 0;
    set_factor(0);
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    drain();

    // D=4: outputs 0,4,...,28 with frame boundaries on 12 and 28
    set_factor(4);
    for (int i = 0; i < 32; i++) send(16'(i), 1'b0);
    drain();
    check("frames_after_d4", {48'd0, frame_count}, 64'd4);

    // Backpressure with D=1
    ready_mode = 1;
    set_factor(1);
    for (int i = 0; i < 64; i++) send(16'($urandom), 1'b0);
    drain();
    ready_mode = 0;

    // Input tlast restarts the phase: D=5, tlast on sample 7
    set_factor(5);
    for (int i = 0; i < 16; i++) send(16'(i), i == 7);
    drain();

    // Factor frozen while enabled, picked up after re-enable
    set_factor(3);
    decim_factor = 8'd2;
    for (int i = 0; i < 12; i++) send(16'(i), 1'b0);
    drain();
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) send(16'(100 + i), 1'b0);
    drain();

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 6);
      n = $urandom_range(10, 40);
      ready_mode = $urandom_range(0, 1);
      set_factor(d);
      for (int i = 0; i < n; i++) send(16'($urandom), ($urandom_range(0, 7) == 0));
      drain();
    end
    ready_mode = 0;

    // Reset with two entries buffered
    set_factor(1);
    ready_mode = 2;
    cycles(1);
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    check("pre_rst_m_tvalid", {63'd0, m_tvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("mid_rst_frame_count", {48'd0, frame_count}, 64'd0);
    check("mid_rst_m_tdata", {32'd0, m_tdata}, 64'd0);
    enable = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    ready_mode = 0;
    set_factor(1);
    send(16'hABCD, 1'b0);
    send(16'h0042, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    check("watchdog", 64'd1, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
